add_sub_pipe: RTL and testbench

- Parametrised, pipelined successor of the ALU adder: WIDTH-bit add or subtract, signed or unsigned, split into STAGES carry-registered segments to shorten the critical path.
- Sits between the EX-stage operand muxes and the ALU result mux; valid/ready handshake on both sides lets the hazard unit stall it.
- Produces S, Zero, Overflow, Negative flags with the same meaning as the single-cycle adder, extended to subtraction.

---
 rtl/add_sub_if.sv | 39 +++
 rtl/add_sub_pipe.sv | 168 ++++++++++++++++
 tb/tb_add_sub_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/add_sub_if.sv
// Operand/result handshake bundle for add_sub_pipe.
// Saturate exists only when ADD_SUB_SATURATE_EN is defined.
interface add_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic             Signed;
`ifdef ADD_SUB_SATURATE_EN
  logic             Saturate;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Zero;
  logic             Overflow;
  logic             Negative;

  modport master (
    output in_valid, A, B, Sub, Signed,
`ifdef ADD_SUB_SATURATE_EN
    output Saturate,
`endif
    output out_ready,
    input  in_ready, out_valid, S, Zero, Overflow, Negative
  );

  modport slave (
    input  in_valid, A, B, Sub, Signed,
`ifdef ADD_SUB_SATURATE_EN
    input  Saturate,
`endif
    input  out_ready,
    output in_ready, out_valid, S, Zero, Overflow, Negative
  );
endinterface

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit add/subtract split into STAGES carry-registered segments.
// Optional clamping of overflowed results when ADD_SUB_SATURATE_EN is defined.
module add_sub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic      clk,
  input logic      reset,
  add_sub_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > 8) || ((WIDTH % STAGES) != 0)) begin : bad_cfg
    $error("add_sub_pipe: WIDTH must be a multiple of STAGES, STAGES in 1..8");
  end

  logic             advance;
  logic             vld_out;
  logic [WIDTH-1:0] s_out;
  logic             zero_out;
  logic             ovf_out;
  logic             neg_out;

  // One global enable: the whole pipe freezes when the result is not taken.
  assign advance       = ~vld_out | bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_out;
  assign bus.S         = s_out;
  assign bus.Zero      = zero_out;
  assign bus.Overflow  = ovf_out;
  assign bus.Negative  = neg_out;

  function automatic logic ovf_flag(input logic am, input logic bm, input logic sm,
                                    input logic cout, input logic sub, input logic sgn);
    logic ovf_s;
    ovf_s = (am == bm) && (sm != am);
    return sgn ? ovf_s : (sub ? ~cout : cout);
  endfunction

`ifdef ADD_SUB_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_value(input logic sgn, input logic sub,
                                                 input logic neg);
    logic signed [WIDTH-1:0] smax;
    logic signed [WIDTH-1:0] smin;
    smax = {1'b0, {(WIDTH-1){1'b1}}};
    smin = {1'b1, {(WIDTH-1){1'b0}}};
    if (sgn)
      return neg ? smin : smax;
    return sub ? '0 : '1;
  endfunction
`endif

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Operand bits not yet consumed; each stage eats the low SEG bits.
    localparam int RW = WIDTH - k * SEG;

    logic [RW-1:0]        a_i;
    logic [RW-1:0]        bp_i;
    logic                 c_i;
    logic                 sub_i;
    logic                 sgn_i;
    logic                 vld_i;
`ifdef ADD_SUB_SATURATE_EN
    logic                 sat_i;
`endif
    logic [SEG:0]         sum;
    logic [(k+1)*SEG-1:0] s_n;

    if (k == 0) begin : src
      assign a_i   = bus.A;
      assign bp_i  = bus.Sub ? ~bus.B : bus.B;
      assign c_i   = bus.Sub;
      assign sub_i = bus.Sub;
      assign sgn_i = bus.Signed;
      assign vld_i = bus.in_valid;
`ifdef ADD_SUB_SATURATE_EN
      assign sat_i = bus.Saturate;
`endif
      assign s_n   = sum[SEG-1:0];
    end else begin : src
      assign a_i   = stg[k-1].mid.a_p;
      assign bp_i  = stg[k-1].mid.bp_p;
      assign c_i   = stg[k-1].mid.c_p;
      assign sub_i = stg[k-1].mid.sub_p;
      assign sgn_i = stg[k-1].mid.sgn_p;
      assign vld_i = stg[k-1].mid.vld_p;
`ifdef ADD_SUB_SATURATE_EN
      assign sat_i = stg[k-1].mid.sat_p;
`endif
      assign s_n   = {sum[SEG-1:0], stg[k-1].mid.s_p};
    end

    assign sum = {1'b0, a_i[SEG-1:0]} + {1'b0, bp_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};

    if (k < STAGES - 1) begin : mid
      logic [RW-SEG-1:0]    a_p;
      logic [RW-SEG-1:0]    bp_p;
      logic [(k+1)*SEG-1:0] s_p;
      logic                 c_p;
      logic                 sub_p;
      logic                 sgn_p;
      logic                 vld_p;
`ifdef ADD_SUB_SATURATE_EN
      logic                 sat_p;
`endif

      // ---- segment k -> segment k+1 boundary ----
      always_ff @(posedge clk) begin
        if (reset)
          vld_p <= 1'b0;
        else if (advance)
          vld_p <= vld_i;
        if (advance) begin
          a_p   <= a_i[RW-1:SEG];
          bp_p  <= bp_i[RW-1:SEG];
          s_p   <= s_n;
          c_p   <= sum[SEG];
          sub_p <= sub_i;
          sgn_p <= sgn_i;
`ifdef ADD_SUB_SATURATE_EN
          sat_p <= sat_i;
`endif
        end
      end
    end else begin : fin
      logic             am;
      logic             bm;
      logic             ovf;
      logic             neg;
      logic             zero;
      logic             clamp_en;
      logic [WIDTH-1:0] res;

      always_comb begin
        am       = a_i[SEG-1];
        bm       = bp_i[SEG-1];
        ovf      = ovf_flag(am, bm, s_n[WIDTH-1], sum[SEG], sub_i, sgn_i);
        neg      = sgn_i & (ovf ? am : s_n[WIDTH-1]);
        res      = s_n;
        clamp_en = 1'b0;
`ifdef ADD_SUB_SATURATE_EN
        clamp_en = sat_i & ovf;
        if (clamp_en)
          res = sat_value(sgn_i, sub_i, neg);
`endif
        // A clamped result is exact in its own terms, so Zero follows it.
        zero     = (res == '0) & (~ovf | clamp_en);
      end

      // ---- final segment -> output register boundary ----
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_out  <= 1'b0;
          s_out    <= '0;
          zero_out <= 1'b0;
          ovf_out  <= 1'b0;
          neg_out  <= 1'b0;
        end else if (advance) begin
          vld_out  <= vld_i;
          s_out    <= res;
          zero_out <= zero;
          ovf_out  <= ovf;
          neg_out  <= neg;
        end
      end
    end
  end
endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed bench for add_sub_pipe (WIDTH=32, STAGES=4): flags, latency,
// reset, back-pressure, and clamping when ADD_SUB_SATURATE_EN is defined.
module tb_add_sub_pipe;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  add_sub_if #(.WIDTH(WIDTH)) bus ();

  add_sub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic sgn, input logic sat,
                        input logic [31:0] es, input logic eo, input logic en,
                        input logic ez);
    bus.A = a; bus.B = b; bus.Sub = sub; bus.Signed = sgn;
`ifdef ADD_SUB_SATURATE_EN
    bus.Saturate = sat;
`else
    if (sat) $error("FAIL %s saturate requested in non-saturating build", tag);
`endif
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      chk({tag, "_early_valid"}, bus.out_valid, 0);
      step();
    end
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_S"}, bus.S, es);
    chk({tag, "_Overflow"}, bus.Overflow, eo);
    chk({tag, "_Negative"}, bus.Negative, en);
    chk({tag, "_Zero"}, bus.Zero, ez);
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic        ssub [8];
  logic [31:0] exp_s [8];
  logic [31:0] held;
  int          sent, recv, stall, cyc;
  logic        st, fo, fi;

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.A = 32'h11; bus.B = 32'h22;
    bus.Sub = 1'b0; bus.Signed = 1'b0; bus.out_ready = 1'b1;
`ifdef ADD_SUB_SATURATE_EN
    bus.Saturate = 1'b0;
`endif
    step();
    chk("rst_valid_0", bus.out_valid, 0);
    step();
    chk("rst_valid_1", bus.out_valid, 0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_S", bus.S, 0);
    chk("rst_flags", {bus.Zero, bus.Overflow, bus.Negative}, 0);
    repeat (STAGES + 1) begin
      step();
      chk("rst_stale", bus.out_valid, 0);
    end

    //        tag       A             B             sub   sgn   sat   S             O     N     Z
    run_op("sovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0);
    run_op("uborrow",  32'h00000003, 32'h00000005, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    run_op("sneg",     32'h00000003, 32'h00000005, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
    run_op("zero_sub", 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    run_op("ucarry0",  32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op("ripple",   32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0);
    run_op("uwrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op("szero",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    run_op("snegovf",  32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_op("sposovf",  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0);
`ifdef ADD_SUB_SATURATE_EN
    run_op("sat_smin", 32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
    run_op("sat_smax", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
    run_op("sat_uadd", 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_op("sat_usub", 32'h00000003, 32'h00000005, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("sat_noovf",32'h00000005, 32'h00000003, 1'b1, 1'b0, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0);
    bus.Saturate = 1'b0;
`endif

    // Reset in the middle of an operation discards it.
    bus.A = 32'h1; bus.B = 32'h2; bus.Sub = 1'b0; bus.Signed = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (STAGES + 1) begin
      chk("midrst_valid", bus.out_valid, 0);
      step();
    end

    // Back-to-back stream with a 3-cycle stall on the first result.
    for (int i = 0; i < 8; i++) begin
      sa[i]    = 32'h0F0F0F0F * i + 32'h00FF00FF;
      sb[i]    = 32'h01000001 * (i + 1);
      ssub[i]  = i[0];
      exp_s[i] = ssub[i] ? sa[i] - sb[i] : sa[i] + sb[i];
    end
    sent = 0; recv = 0; stall = 0; cyc = 0; held = '0;
    while (recv < 8 && cyc < 60) begin
      st = bus.out_valid && (stall < 3);
      bus.out_ready = !st;
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.A = sa[sent]; bus.B = sb[sent]; bus.Sub = ssub[sent]; bus.Signed = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (st) begin
        chk("bp_in_ready", bus.in_ready, 0);
        if (stall == 0) held = bus.S;
        else chk("bp_hold_S", bus.S, held);
        stall++;
      end
      fo = bus.out_valid && bus.out_ready;
      fi = bus.in_valid && bus.in_ready;
      if (fo) begin
        chk("bp_order", bus.S, exp_s[recv]);
        recv++;
      end
      if (fi) sent++;
      step();
      cyc++;
    end
    chk("bp_count", recv, 8);
    chk("bp_stalled", stall, 3);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (STAGES + 1) begin
      #1;
      chk("bp_no_extra", bus.out_valid, 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
